// File: rtl/ws2812_cfg_decoder_if.sv
// FIFO read port and config-bank outputs of ws2812_cfg_decoder.
// slave = decoder side, master = FIFO/driver side.
interface ws2812_cfg_decoder_if #(
    parameter int PHY_FIFO_WIDTH = 8,
    parameter int NUM_REGS       = 4,
    parameter int REG_BYTES      = 2
);
    localparam int RW = REG_BYTES * PHY_FIFO_WIDTH;

    logic                      f_empty;
    logic [PHY_FIFO_WIDTH-1:0] fifo_read_data;
    logic                      fifo_read_en;
    logic [NUM_REGS*RW-1:0]    cfg_data;
    logic                      write;
    logic [7:0]                write_idx;
    logic                      busy;
    logic                      err;

    modport master (
        output f_empty, fifo_read_data,
        input  fifo_read_en, cfg_data, write,
        input  write_idx, busy, err
    );

    modport slave (
        input  f_empty, fifo_read_data,
        output fifo_read_en, cfg_data, write,
        output write_idx, busy, err
    );
endinterface

// File: rtl/ws2812_cfg_decoder.sv
// Opcode/value stream decoder loading the WS2812 config register bank.
// Define WS_CFG_TIMEOUT_EN to abort commands stalled between value bytes.
module ws2812_cfg_decoder #(
    parameter int PHY_FIFO_WIDTH = 8,
    parameter int NUM_REGS       = 4,
    parameter int REG_BYTES      = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input logic                  clk,
    input logic                  reset,
    ws2812_cfg_decoder_if.slave  bus
);
    localparam int W  = PHY_FIFO_WIDTH;
    localparam int RW = REG_BYTES * W;
    localparam int CW = (REG_BYTES > 1) ? $clog2(REG_BYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(REG_BYTES - 1);

    if (W < 8 || NUM_REGS < 1 || NUM_REGS > 126 ||
        REG_BYTES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("ws2812_cfg_decoder: illegal parameters");
    end

    typedef enum logic [1:0] {HOLD, WAIT, CAPTURE, COMMIT} state_t;

    state_t          state;
    logic            val_ph;
    logic [CW-1:0]   byte_cnt;
    logic [7:0]      sel_idx;
    logic [RW-1:0]   stage;
    logic [7:0]      op;
    logic            op_ok;

    assign op    = bus.fifo_read_data[7:0];
    assign op_ok = (op != 8'h00) && (op <= 8'(NUM_REGS));

`ifdef WS_CFG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= HOLD;
            val_ph           <= 1'b0;
            byte_cnt         <= '0;
            sel_idx          <= '0;
            stage            <= '0;
            bus.cfg_data     <= '0;
            bus.fifo_read_en <= 1'b0;
            bus.write        <= 1'b0;
            bus.write_idx    <= '0;
            bus.busy         <= 1'b0;
            bus.err          <= 1'b0;
`ifdef WS_CFG_TIMEOUT_EN
            to_cnt           <= '0;
`endif
        end else begin
            bus.fifo_read_en <= 1'b0;
            bus.write        <= 1'b0;
            bus.err          <= 1'b0;
            unique case (state)
                HOLD: begin
                    if (!bus.f_empty) begin
                        bus.fifo_read_en <= 1'b1;
                        state            <= WAIT;
`ifdef WS_CFG_TIMEOUT_EN
                        to_cnt           <= '0;
`endif
                    end
`ifdef WS_CFG_TIMEOUT_EN
                    // stalled mid-command: drop the partial value
                    else if (bus.busy) begin
                        if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                            bus.err  <= 1'b1;
                            bus.busy <= 1'b0;
                            val_ph   <= 1'b0;
                            stage    <= '0;
                            to_cnt   <= '0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
`else
                    else begin
                        state <= HOLD;
                    end
`endif
                end
                WAIT: state <= CAPTURE;
                CAPTURE: begin
                    if (!val_ph) begin
                        state <= HOLD;
                        if (op_ok) begin
                            sel_idx  <= op - 8'd1;
                            byte_cnt <= '0;
                            bus.busy <= 1'b1;
                            val_ph   <= 1'b1;
                        end else if (op == 8'hFF) begin
                            bus.cfg_data <= '0;
                        end else if (op != 8'h00) begin
                            bus.err <= 1'b1;
                        end
                    end else begin
                        stage    <= (stage << W) | RW'(bus.fifo_read_data);
                        byte_cnt <= byte_cnt + 1'b1;
                        state    <= (byte_cnt == LAST) ? COMMIT : HOLD;
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (sel_idx == 8'(i))
                            bus.cfg_data[i*RW +: RW] <= stage;
                    end
                    bus.write     <= 1'b1;
                    bus.write_idx <= sel_idx;
                    bus.busy      <= 1'b0;
                    val_ph        <= 1'b0;
                    state         <= HOLD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812_cfg_decoder.sv
// Directed bench for ws2812_cfg_decoder with a one-cycle-latency FIFO model.
// Timeout vectors run only when WS_CFG_TIMEOUT_EN is defined.
module tb_ws2812_cfg_decoder;
`ifdef WS_CFG_TIMEOUT_EN
    localparam int TO = 20;
`else
    localparam int TO = 1000;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ws2812_cfg_decoder_if #(
        .PHY_FIFO_WIDTH(8), .NUM_REGS(4), .REG_BYTES(2)
    ) bus ();

    ws2812_cfg_decoder #(
        .PHY_FIFO_WIDTH(8), .NUM_REGS(4),
        .REG_BYTES(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // FIFO model: writer = initial block, reader = popping process
    logic [7:0] mem [0:255];
    logic [7:0] wp = 8'd0;
    logic [7:0] rp = 8'd0;

    assign bus.f_empty = (wp == rp);

    always @(posedge clk) begin
        if (bus.fifo_read_en && (wp != rp)) begin
            bus.fifo_read_data <= mem[rp];
            rp <= rp + 8'd1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int npop = 0, wr_cnt = 0, err_cnt = 0, viol = 0;
    int wr_cyc = 0, err_cyc = 0;
    int pop_log [0:63];
    logic [7:0] idx_log [0:63];
    logic p_rd = 1'b0, p_wr = 1'b0, p_er = 1'b0;

    always @(negedge clk) begin
        if (bus.fifo_read_en) begin
            if (npop < 64) pop_log[npop] = cyc;
            npop++;
        end
        if (bus.write) begin
            if (wr_cnt < 64) idx_log[wr_cnt] = bus.write_idx;
            wr_cnt++;
            wr_cyc = cyc;
        end
        if (bus.err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if ((bus.fifo_read_en && p_rd) || (bus.write && p_wr) ||
            (bus.err && p_er) || (bus.write && bus.err))
            viol++;
        p_rd = bus.fifo_read_en;
        p_wr = bus.write;
        p_er = bus.err;
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp] = b;
        wp = wp + 8'd1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] reg_of(input int i);
        return bus.cfg_data[i*16 +: 16];
    endfunction

    int w0, e0, p0;

    initial begin
        idle(3);
        check("rst_cfg", bus.cfg_data, 64'h0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_rd_en", bus.fifo_read_en, 1'b0);
        check("rst_write", bus.write, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_idx", bus.write_idx, 8'h0);
        reset = 1'b0;
        idle(1);

        // single command and its latency
        push(8'h01); push(8'h12); push(8'h34);
        idle(14);
        check("t1_wr_cnt", wr_cnt, 1);
        check("t1_idx", idx_log[0], 8'd0);
        check("t1_reg0", reg_of(0), 16'h1234);
        check("t1_busy", bus.busy, 1'b0);
        check("t1_latency", 64'(wr_cyc - pop_log[0]), 64'd9);

        // back-to-back commands
        push(8'h04); push(8'h00); push(8'h3C);
        push(8'h02); push(8'h00); push(8'h01);
        idle(25);
        check("t2_wr_cnt", wr_cnt, 3);
        check("t2_idx_a", idx_log[1], 8'd3);
        check("t2_idx_b", idx_log[2], 8'd1);
        check("t2_cfg", bus.cfg_data, 64'h003C_0000_0001_1234);
        check("t2_idx_hold", bus.write_idx, 8'd1);

        // invalid opcode, NOP, then a valid write
        push(8'h07);
        idle(6);
        check("t3_err_inv", err_cnt, 1);
        check("t3_nowr_inv", wr_cnt, 3);
        push(8'h00);
        idle(6);
        check("t3_err_nop", err_cnt, 1);
        check("t3_nowr_nop", wr_cnt, 3);
        push(8'h03); push(8'hAB); push(8'hCD);
        idle(14);
        check("t3_cfg", bus.cfg_data, 64'h003C_ABCD_0001_1234);
        check("t3_idx", bus.write_idx, 8'd2);

        // partial value never reaches cfg_data
        push(8'h02); push(8'h00);
        idle(10);
        check("t4_busy_mid", bus.busy, 1'b1);
        check("t4_cfg_mid", bus.cfg_data, 64'h003C_ABCD_0001_1234);
        push(8'h77);
        idle(8);
        check("t4_cfg", bus.cfg_data, 64'h003C_ABCD_0077_1234);
        check("t4_busy", bus.busy, 1'b0);

        // clear all
        w0 = wr_cnt;
        push(8'hFF);
        idle(8);
        check("t5_cfg", bus.cfg_data, 64'h0);
        check("t5_nowr", wr_cnt, w0);
        check("t5_err", err_cnt, 1);

`ifdef WS_CFG_TIMEOUT_EN
        e0 = err_cnt;
        push(8'h01); push(8'h55);
        idle(45);
        p0 = pop_log[npop-1];
        check("to_err", err_cnt, e0 + 1);
        check("to_when", 64'(err_cyc - p0), 64'd22);
        check("to_cfg", bus.cfg_data, 64'h0);
        check("to_busy", bus.busy, 1'b0);
        push(8'h01); push(8'h00); push(8'h09);
        idle(14);
        check("to_reg0", reg_of(0), 16'h0009);
`endif

        // reset in the middle of a command
        push(8'h04); push(8'hBE); push(8'hEF);
        idle(14);
        check("t6_reg3", reg_of(3), 16'hBEEF);
        push(8'h01); push(8'hAA);
        idle(7);
        check("t6_busy_pre", bus.busy, 1'b1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("t6_cfg", bus.cfg_data, 64'h0);
        check("t6_busy", bus.busy, 1'b0);
        check("t6_idx", bus.write_idx, 8'h0);
        check("t6_rd_en", bus.fifo_read_en, 1'b0);
        check("t6_write", bus.write, 1'b0);
        check("t6_err", bus.err, 1'b0);
        push(8'h01); push(8'h00); push(8'h05);
        idle(14);
        check("t6_after", bus.cfg_data, 64'h5);

        check("pulse_rules", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
